// File: rtl/comb_sched_pkg.sv
// Shared types and defaults for the round-robin combination scheduler.
// Holds the FSM encoding and the operand/result/watchdog widths.
package comb_sched_pkg;

  localparam int NM_W_DEF  = 4;
  localparam int RES_W_DEF = 13;
  localparam int WD_W      = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LAUNCH = 2'd1,
    WAIT   = 2'd2,
    RESP   = 2'd3
  } sched_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set request at or after ptr.
// Returns a one-hot grant, its index and whether anything was granted.
module rr_arbiter #(
  parameter int NREQ  = 4,
  parameter int IDX_W = $clog2(NREQ)
) (
  input  logic [NREQ-1:0]  req,
  input  logic [IDX_W-1:0] ptr,
  output logic [NREQ-1:0]  gnt,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             gnt_any
);

  int               j;
  logic [IDX_W-1:0] jj;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    gnt_any = 1'b0;
    j       = 0;
    jj      = '0;
    for (int k = 0; k < NREQ; k++) begin
      j = int'(ptr) + k;
      if (j >= NREQ) j = j - NREQ;
      jj = IDX_W'(j);
      if (!gnt_any && req[jj]) begin
        gnt_any     = 1'b1;
        gnt[jj]     = 1'b1;
        gnt_idx     = jj;
      end
    end
  end

endmodule

// File: rtl/comb_rr_scheduler.sv
// Shares one C(n,m) engine among NREQ single-slot requesters.
// Round-robin grant, start/done sequencing and a hang watchdog.
module comb_rr_scheduler
  import comb_sched_pkg::*;
#(
  parameter int NREQ    = 4,
  parameter int NM_W    = NM_W_DEF,
  parameter int RES_W   = RES_W_DEF,
  parameter int TIMEOUT = 65535
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [NREQ*NM_W-1:0] req_n,
  input  logic [NREQ*NM_W-1:0] req_m,
  output logic [NREQ-1:0]      rsp_valid,
  input  logic [NREQ-1:0]      rsp_ready,
  output logic [RES_W-1:0]     rsp_result,
  output logic                 rsp_err,
  output logic                 eng_start,
  output logic [NM_W-1:0]      eng_n,
  output logic [NM_W-1:0]      eng_m,
  output logic                 eng_rst,
  input  logic                 eng_done,
  input  logic [RES_W-1:0]     eng_result
);

  localparam int IDX_W = $clog2(NREQ);
  localparam logic [WD_W-1:0] TO_LIM = WD_W'(TIMEOUT);

  sched_state_e state_q, state_d;

  logic [NREQ-1:0]  full_q, full_d;
  logic [NM_W-1:0]  sn_q [NREQ];
  logic [NM_W-1:0]  sn_d [NREQ];
  logic [NM_W-1:0]  sm_q [NREQ];
  logic [NM_W-1:0]  sm_d [NREQ];
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [NREQ-1:0]  gnt_q, gnt_d;
  logic [NM_W-1:0]  en_q, en_d;
  logic [NM_W-1:0]  em_q, em_d;
  logic [RES_W-1:0] res_q, res_d;
  logic             err_q, err_d;
  logic             abort_q, abort_d;
  logic [WD_W-1:0]  wd_q, wd_d;

  logic [NREQ-1:0]  acc;
  logic [NREQ-1:0]  arb_gnt;
  logic [IDX_W-1:0] arb_idx;
  logic             arb_any;

  // Slots are only full while unserved or in RESP, so the
  // full vector is exactly the set eligible for a new grant.
  rr_arbiter #(
    .NREQ  (NREQ),
    .IDX_W (IDX_W)
  ) u_arb (
    .req     (full_q),
    .ptr     (ptr_q),
    .gnt     (arb_gnt),
    .gnt_idx (arb_idx),
    .gnt_any (arb_any)
  );

  always_comb begin
    state_d = state_q;
    full_d  = full_q;
    sn_d    = sn_q;
    sm_d    = sm_q;
    ptr_d   = ptr_q;
    gnt_d   = gnt_q;
    en_d    = en_q;
    em_d    = em_q;
    res_d   = res_q;
    err_d   = err_q;
    abort_d = 1'b0;
    wd_d    = wd_q;

    acc = req_valid & ~full_q;
    for (int i = 0; i < NREQ; i++) begin
      if (acc[i]) begin
        full_d[i] = 1'b1;
        sn_d[i]   = req_n[i*NM_W +: NM_W];
        sm_d[i]   = req_m[i*NM_W +: NM_W];
      end
    end

    unique case (state_q)
      IDLE: begin
        if (arb_any) begin
          gnt_d = arb_gnt;
          if (arb_idx == IDX_W'(NREQ-1)) ptr_d = '0;
          else ptr_d = arb_idx + 1'b1;
          if (sm_q[arb_idx] > sn_q[arb_idx]) begin
            res_d   = '0;
            err_d   = 1'b0;
            state_d = RESP;
          end else begin
            en_d    = sn_q[arb_idx];
            em_d    = sm_q[arb_idx];
            state_d = LAUNCH;
          end
        end
      end
      LAUNCH: begin
        wd_d    = '0;
        state_d = WAIT;
      end
      WAIT: begin
        wd_d = wd_q + 1'b1;
        // first WAIT cycle (wd_q == 0) may see a stale done level
        if (wd_q != '0 && eng_done) begin
          res_d   = eng_result;
          err_d   = 1'b0;
          state_d = RESP;
        end else if (wd_d == TO_LIM) begin
          abort_d = 1'b1;
          res_d   = '0;
          err_d   = 1'b1;
          state_d = RESP;
        end
      end
      RESP: begin
        if (|(rsp_ready & gnt_q)) begin
          full_d  = full_d & ~gnt_q;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      full_q  <= '0;
      ptr_q   <= '0;
      gnt_q   <= '0;
      en_q    <= '0;
      em_q    <= '0;
      res_q   <= '0;
      err_q   <= 1'b0;
      abort_q <= 1'b0;
      wd_q    <= '0;
      for (int i = 0; i < NREQ; i++) begin
        sn_q[i] <= '0;
        sm_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      full_q  <= full_d;
      ptr_q   <= ptr_d;
      gnt_q   <= gnt_d;
      en_q    <= en_d;
      em_q    <= em_d;
      res_q   <= res_d;
      err_q   <= err_d;
      abort_q <= abort_d;
      wd_q    <= wd_d;
      sn_q    <= sn_d;
      sm_q    <= sm_d;
    end
  end

  assign req_ready  = ~full_q;
  assign rsp_valid  = (state_q == RESP) ? gnt_q : '0;
  assign rsp_result = res_q;
  assign rsp_err    = err_q;
  assign eng_start  = (state_q == LAUNCH);
  assign eng_n      = en_q;
  assign eng_m      = em_q;
  assign eng_rst    = rst | abort_q;

endmodule

// File: tb/tb_comb_rr_scheduler.sv
// Directed bench for comb_rr_scheduler with a behavioural engine stub.
// Watchdog is shortened to 20 cycles so the hang case stays short.
module tb_comb_rr_scheduler;

  localparam int NREQ = 4;
  localparam int NM_W = 4;
  localparam int RES_W = 13;
  localparam int TO = 20;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [NREQ-1:0]  req_valid = '0;
  logic [NREQ-1:0]  rsp_ready = '0;
  logic [NREQ*NM_W-1:0] req_n = '0;
  logic [NREQ*NM_W-1:0] req_m = '0;
  logic [NREQ-1:0]  req_ready;
  logic [NREQ-1:0]  rsp_valid;
  logic [RES_W-1:0] rsp_result;
  logic             rsp_err;
  logic             eng_start;
  logic [NM_W-1:0]  eng_n;
  logic [NM_W-1:0]  eng_m;
  logic             eng_rst;
  logic             eng_done = 1'b0;
  logic [RES_W-1:0] eng_result = '0;

  int tests = 0;
  int fails = 0;
  int starts = 0;
  bit hang = 1'b0;

  always #5 clk = ~clk;

  comb_rr_scheduler #(
    .NREQ(NREQ), .NM_W(NM_W), .RES_W(RES_W), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_n(req_n), .req_m(req_m),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .rsp_err(rsp_err),
    .eng_start(eng_start), .eng_n(eng_n), .eng_m(eng_m),
    .eng_rst(eng_rst), .eng_done(eng_done),
    .eng_result(eng_result)
  );

  function automatic int comb(input int n, input int m);
    int r = 1;
    for (int i = 0; i < m; i++) r = r * (n - i) / (i + 1);
    return r;
  endfunction

  // engine stub: done pulse 4 cycles after start, or never when hung
  logic [3:0] mn = '0;
  logic [3:0] mm = '0;
  int  mcnt = 0;
  bit  busy = 1'b0;

  always @(posedge clk) begin
    eng_done <= 1'b0;
    if (eng_start) starts <= starts + 1;
    if (eng_rst) begin
      busy <= 1'b0;
    end else if (eng_start) begin
      busy <= 1'b1;
      mcnt <= 3;
      mn   <= eng_n;
      mm   <= eng_m;
    end else if (busy && !hang) begin
      if (mcnt == 0) begin
        eng_done   <= 1'b1;
        eng_result <= RES_W'(comb(int'(mn), int'(mm)));
        busy       <= 1'b0;
      end else begin
        mcnt <= mcnt - 1;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int i, input int n, input int m);
    req_valid[i] = 1'b1;
    req_n[i*NM_W +: NM_W] = NM_W'(n);
    req_m[i*NM_W +: NM_W] = NM_W'(m);
    tick();
    req_valid[i] = 1'b0;
  endtask

  task automatic expect_rsp(input string tag, input int i,
                            input int res, input bit err);
    int c = 0;
    while (!rsp_valid[i] && c < 200) begin
      tick();
      c++;
    end
    check({tag, "_valid"}, 32'(rsp_valid), 32'(1 << i));
    check({tag, "_result"}, 32'(rsp_result), 32'(res));
    check({tag, "_err"}, 32'(rsp_err), 32'(err));
    rsp_ready[i] = 1'b1;
    tick();
    rsp_ready[i] = 1'b0;
    check({tag, "_ready_back"}, 32'(req_ready[i]), 32'd1);
  endtask

  task automatic wait_start(input string tag);
    int c = 0;
    while (!eng_start && c < 50) begin
      tick();
      c++;
    end
    check({tag, "_start_seen"}, 32'(eng_start), 32'd1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    #1;
  endtask

  initial begin
    int s0;
    int c;

    rst = 1'b1;
    tick();
    tick();
    check("rst_req_ready", 32'(req_ready), 32'hF);
    check("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    check("rst_rsp_result", 32'(rsp_result), 32'h0);
    check("rst_rsp_err", 32'(rsp_err), 32'h0);
    check("rst_eng_start", 32'(eng_start), 32'h0);
    check("rst_eng_nm", 32'({eng_n, eng_m}), 32'h0);
    check("rst_eng_rst", 32'(eng_rst), 32'h1);
    rst = 1'b0;
    #1;
    check("rel_eng_rst", 32'(eng_rst), 32'h0);

    // single request
    s0 = starts;
    send(0, 5, 2);
    expect_rsp("c5_2", 0, 10, 1'b0);
    check("c5_2_starts", 32'(starts - s0), 32'd1);

    // edge operands
    send(0, 4, 0);
    expect_rsp("c4_0", 0, 1, 1'b0);
    send(0, 4, 4);
    expect_rsp("c4_4", 0, 1, 1'b0);
    s0 = starts;
    req_valid[0] = 1'b1;
    req_n[3:0] = 4'd2;
    req_m[3:0] = 4'd3;
    tick();
    req_valid[0] = 1'b0;
    check("m_gt_n_early", 32'(rsp_valid), 32'h0);
    tick();
    check("m_gt_n_valid", 32'(rsp_valid), 32'h1);
    expect_rsp("m_gt_n", 0, 0, 1'b0);
    check("m_gt_n_starts", 32'(starts - s0), 32'd0);

    // all four at once, pointer from 0
    do_reset();
    req_valid = 4'hF;
    req_n = {4'd9, 4'd8, 4'd7, 4'd6};
    req_m = {4'd1, 4'd4, 4'd2, 4'd3};
    tick();
    req_valid = '0;
    expect_rsp("rr0", 0, 20, 1'b0);
    send(0, 5, 2);
    expect_rsp("rr1", 1, 21, 1'b0);
    expect_rsp("rr2", 2, 70, 1'b0);
    expect_rsp("rr3", 3, 9, 1'b0);
    expect_rsp("rr0_again", 0, 10, 1'b0);

    // backpressure on requester 1
    send(1, 5, 2);
    c = 0;
    while (!rsp_valid[1] && c < 200) begin
      tick();
      c++;
    end
    s0 = starts;
    req_valid[2] = 1'b1;
    req_n[11:8] = 4'd6;
    req_m[11:8] = 4'd3;
    for (int k = 0; k < 10; k++) begin
      tick();
      req_valid[2] = 1'b0;
      check("bp_valid", 32'(rsp_valid), 32'h2);
      check("bp_result", 32'(rsp_result), 32'd10);
    end
    check("bp_no_start", 32'(starts - s0), 32'd0);
    expect_rsp("bp1", 1, 10, 1'b0);
    expect_rsp("bp2", 2, 20, 1'b0);

    // hung engine
    hang = 1'b1;
    send(3, 5, 2);
    wait_start("hang");
    c = 0;
    while (!eng_rst && c < 100) begin
      tick();
      c++;
    end
    check("hang_rst_delay", 32'(c), 32'd21);
    check("hang_valid", 32'(rsp_valid), 32'h8);
    check("hang_err", 32'(rsp_err), 32'd1);
    check("hang_result", 32'(rsp_result), 32'd0);
    tick();
    check("hang_rst_pulse", 32'(eng_rst), 32'd0);
    expect_rsp("hang_rsp", 3, 0, 1'b1);
    hang = 1'b0;
    send(3, 7, 2);
    expect_rsp("after_hang", 3, 21, 1'b0);

    // reset during WAIT
    send(0, 6, 3);
    wait_start("midrst");
    tick();
    tick();
    rst = 1'b1;
    #1;
    check("midrst_eng_rst", 32'(eng_rst), 32'd1);
    tick();
    check("midrst_valid", 32'(rsp_valid), 32'h0);
    check("midrst_ready", 32'(req_ready), 32'hF);
    check("midrst_eng_rst2", 32'(eng_rst), 32'd1);
    rst = 1'b0;
    #1;
    check("midrst_rel", 32'(eng_rst), 32'd0);
    for (int k = 0; k < 10; k++) begin
      tick();
      check("midrst_no_rsp", 32'(rsp_valid), 32'h0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
